// File: rtl/chat_scroll_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chat_scroll_display_pkg
// Description : Shared raster geometry, ASCII bounds and render-region type
//               for the chat scroll display and its font ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package chat_scroll_display_pkg;

  localparam int FONT_W   = 8;     // glyph width in pixels
  localparam int H_ACTIVE = 1024;  // visible pixels per line
  localparam int V_ACTIVE = 768;   // visible lines per frame

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LAST  = 8'h7E;

  // What the S1 decoder found under the current pixel
  typedef enum logic [1:0] {
    RGN_NONE   = 2'd0,
    RGN_HEADER = 2'd1,
    RGN_ROW    = 2'd2
  } region_e;

  // Only printable, non-space codes carry ink; NUL, controls, space and
  // anything above 0x7E all render as blank cells.
  function automatic logic has_ink(input logic [7:0] code);
    return (code > ASCII_SPACE) && (code <= ASCII_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chat_scroll_display_font_rom.sv
`default_nettype none
// ============================================================================
// Module      : chat_font_rom
// Description : Glyph ROM, 8-bit char code + glyph row -> 8-pixel bitmap,
//               one-cycle registered read. MSB is the leftmost pixel.
// Ports       : clk     in   read clock
//               i_code  in   8-bit character code
//               i_row   in   glyph row (0 = top)
//               o_bits  out  registered bitmap for (i_code, i_row)
// Revision    : 1.0 - initial release
// ============================================================================
module chat_font_rom
  import chat_scroll_display_pkg::*;
#(
  parameter int FONT_H = 12
) (
  input  logic       clk,
  input  logic [7:0] i_code,
  input  logic [3:0] i_row,
  output logic [7:0] o_bits
);

  logic [7:0] w_bits;
  logic [7:0] r_bits;

  // Compact code-pattern glyph set: the top and bottom rows are left empty
  // as inter-line spacing; every inked row shows a solid left stroke plus
  // the low seven code bits, so each character is visually distinct.
  always_comb begin
    w_bits = 8'h00;
    if (has_ink(i_code) && (i_row != 4'd0) && (int'(i_row) < FONT_H - 1))
      w_bits = {1'b1, i_code[6:0]};
  end

  always_ff @(posedge clk) begin
    r_bits <= w_bits;
  end

  assign o_bits = r_bits;

endmodule
`default_nettype wire

// File: rtl/chat_scroll_display.sv
`default_nettype none
// ============================================================================
// Module      : chat_scroll_display
// Description : NCHAN scrolling chat histories (NLINES x NCHAR chars each)
//               plus per-channel headers rendered into the 1024x768 raster.
//               Lines are pushed with a valid/ready handshake that only opens
//               during vertical blanking, so the picture never tears.
// Ports       : clock_65mhz in  pixel clock
//               reset_n     in  asynchronous active-low reset
//               hcount/vcount in current pixel position
//               headers     in  header text, channel c at [c*NCHAR*8 +: NCHAR*8]
//               line_valid/line_chan/line_data in push request
//               line_ready  out push accepted on valid & ready
//               clear       in  per-channel history clear (level)
//               count       out lines held per channel, 4 bits each
//               pixels      out RGB for (hcount,vcount), 3 cycles late
// Revision    : 1.0 - initial release
// ============================================================================
module chat_scroll_display
  import chat_scroll_display_pkg::*;
#(
  parameter int NCHAN   = 2,
  parameter int NLINES  = 5,
  parameter int NCHAR   = 16,
  parameter int X0      = 150,
  parameter int XSTEP   = 400,
  parameter int Y0      = 25,
  parameter int YSTEP   = 50,
  parameter int FONT_H  = 12,
  parameter int VACTIVE = V_ACTIVE,
  localparam int CHW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                     clock_65mhz,
  input  logic                     reset_n,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic [NCHAN*NCHAR*8-1:0] headers,
  input  logic                     line_valid,
  input  logic [CHW-1:0]           line_chan,
  input  logic [NCHAR*8-1:0]       line_data,
  output logic                     line_ready,
  input  logic [NCHAN-1:0]         clear,
  output logic [NCHAN*4-1:0]       count,
  output logic [2:0]               pixels
);

  localparam int LW    = NCHAR * 8;
  localparam int HW    = (NLINES > 1) ? $clog2(NLINES) : 1;
  localparam int CIW   = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int DEPTH = NCHAN * NLINES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HIW   = $clog2(NCHAN * LW);
  localparam int LIW   = $clog2(LW);

  // ---------------------------------------------------------------- history
  logic [LW-1:0] r_store [DEPTH];
  logic [HW-1:0] r_head  [NCHAN];
  logic [3:0]    r_count [NCHAN];
  logic          r_ready;
  logic          w_push;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;

  assign w_push    = line_valid & r_ready;
  // A clear landing on the same edge wins; the line is simply not stored.
  assign w_wr_en   = w_push & ~clear[line_chan];
  assign w_wr_addr = AW'(int'(line_chan) * NLINES + int'(r_head[line_chan]));
  assign line_ready = r_ready;

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (int'(vcount) >= VACTIVE) && !clear[line_chan] &&
                 (int'(line_chan) < NCHAN);
    end
  end

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_head[c]  <= '0;
        r_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (clear[c]) begin
          r_head[c]  <= '0;
          r_count[c] <= '0;
        end else if (w_push && (int'(line_chan) == c)) begin
          r_head[c] <= (int'(r_head[c]) == NLINES - 1) ? '0 : r_head[c] + 1'b1;
          // Once full the write overwrites the oldest slot, scrolling the column
          if (int'(r_count[c]) < NLINES)
            r_count[c] <= r_count[c] + 4'd1;
        end
      end
    end
  end

  // Contents are don't-care after reset, so the store carries no reset
  always_ff @(posedge clock_65mhz) begin
    if (w_wr_en)
      r_store[w_wr_addr] <= line_data;
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_count
    assign count[c*4 +: 4] = r_count[c];
  end

  // ------------------------------------------------------- S1: region decode
  region_e        w_s1_rgn;
  logic [CHW-1:0] w_s1_col;
  logic [HW-1:0]  w_s1_row;
  logic [CIW-1:0] w_s1_cidx;
  logic [2:0]     w_s1_bit;
  logic [3:0]     w_s1_grow;
  logic           w_xhit;
  logic           w_yhdr;
  logic           w_yrow;

  always_comb begin
    int xoff;
    int yoff;
    xoff      = 0;
    yoff      = 0;
    w_xhit    = 1'b0;
    w_yhdr    = 1'b0;
    w_yrow    = 1'b0;
    w_s1_col  = '0;
    w_s1_row  = '0;
    w_s1_rgn  = RGN_NONE;
    for (int c = 0; c < NCHAN; c++) begin
      // Full-width compares: a column running past the right edge is clipped
      if ((int'(hcount) >= X0 + c*XSTEP) &&
          (int'(hcount) <  X0 + c*XSTEP + NCHAR*FONT_W) &&
          (int'(hcount) <  H_ACTIVE)) begin
        w_xhit   = 1'b1;
        w_s1_col = CHW'(c);
        xoff     = int'(hcount) - (X0 + c*XSTEP);
      end
    end
    if (int'(vcount) < VACTIVE) begin
      if ((int'(vcount) >= Y0) && (int'(vcount) < Y0 + FONT_H)) begin
        w_yhdr = 1'b1;
        yoff   = int'(vcount) - Y0;
      end
      for (int r = 0; r < NLINES; r++) begin
        if ((int'(vcount) >= Y0 + (r+1)*YSTEP) &&
            (int'(vcount) <  Y0 + (r+1)*YSTEP + FONT_H)) begin
          w_yrow   = 1'b1;
          w_s1_row = HW'(r);
          yoff     = int'(vcount) - (Y0 + (r+1)*YSTEP);
        end
      end
    end
    if (w_xhit && w_yhdr)
      w_s1_rgn = RGN_HEADER;
    else if (w_xhit && w_yrow)
      w_s1_rgn = RGN_ROW;
    w_s1_cidx = CIW'(xoff / FONT_W);
    w_s1_bit  = 3'(xoff % FONT_W);
    w_s1_grow = 4'(yoff);
  end

  region_e        r_s1_rgn;
  logic [CHW-1:0] r_s1_col;
  logic [HW-1:0]  r_s1_row;
  logic [CIW-1:0] r_s1_cidx;
  logic [2:0]     r_s1_bit;
  logic [3:0]     r_s1_grow;

  // -------------------------------------------------------- S2: char fetch
  logic [7:0] w_s2_code;

  always_comb begin
    logic [LW-1:0] line;
    int            slot;
    line = '0;
    slot = 0;
    if (r_s1_rgn == RGN_HEADER) begin
      line = headers[HIW'(int'(r_s1_col) * LW) +: LW];
    end else if ((r_s1_rgn == RGN_ROW) &&
                 (int'(r_s1_row) < int'(r_count[r_s1_col]))) begin
      // Oldest held line sits at head - count; NLINES keeps the sum positive
      slot = (int'(r_head[r_s1_col]) + NLINES - int'(r_count[r_s1_col]) +
              int'(r_s1_row)) % NLINES;
      line = r_store[AW'(int'(r_s1_col) * NLINES + slot)];
    end
    w_s2_code = line[LIW'((NCHAR - 1 - int'(r_s1_cidx)) * FONT_W) +: FONT_W];
  end

  logic [7:0] r_s2_code;
  logic [3:0] r_s2_grow;
  logic [2:0] r_s2_bit;
  logic       r_s2_en;

  // ------------------------------------------------- S3: font + bit select
  logic [7:0] w_glyph;
  logic [2:0] r_s3_bit;
  logic       r_s3_en;

  chat_font_rom #(
    .FONT_H (FONT_H)
  ) u_font_rom (
    .clk    (clock_65mhz),
    .i_code (r_s2_code),
    .i_row  (r_s2_grow),
    .o_bits (w_glyph)
  );

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_rgn  <= RGN_NONE;
      r_s1_col  <= '0;
      r_s1_row  <= '0;
      r_s1_cidx <= '0;
      r_s1_bit  <= '0;
      r_s1_grow <= '0;
      r_s2_code <= '0;
      r_s2_grow <= '0;
      r_s2_bit  <= '0;
      r_s2_en   <= 1'b0;
      r_s3_bit  <= '0;
      r_s3_en   <= 1'b0;
    end else begin
      r_s1_rgn  <= w_s1_rgn;
      r_s1_col  <= w_s1_col;
      r_s1_row  <= w_s1_row;
      r_s1_cidx <= w_s1_cidx;
      r_s1_bit  <= w_s1_bit;
      r_s1_grow <= w_s1_grow;
      r_s2_code <= w_s2_code;
      r_s2_grow <= r_s1_grow;
      r_s2_bit  <= r_s1_bit;
      r_s2_en   <= (r_s1_rgn != RGN_NONE);
      r_s3_bit  <= r_s2_bit;
      r_s3_en   <= r_s2_en;
    end
  end

  // Gating with the reset-cleared enable blanks the output the instant
  // reset asserts, even though the ROM register itself is not reset.
  assign pixels = {3{r_s3_en & w_glyph[~r_s3_bit]}};

endmodule
`default_nettype wire

// File: tb/tb_chat_scroll_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_chat_scroll_display
// Description : Directed self-checking bench for chat_scroll_display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chat_scroll_display;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [10:0]  hcount;
  logic [9:0]   vcount;
  logic [255:0] headers;
  logic         line_valid;
  logic [0:0]   line_chan;
  logic [127:0] line_data;
  logic         line_ready;
  logic [1:0]   clear;
  logic [7:0]   count;
  logic [2:0]   pixels;

  int checks   = 0;
  int failures = 0;

  logic [127:0] hdr     [2];
  logic [127:0] exp_txt [2][5];

  always #5 clk = ~clk;

  chat_scroll_display dut (
    .clock_65mhz (clk),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .headers     (headers),
    .line_valid  (line_valid),
    .line_chan   (line_chan),
    .line_data   (line_data),
    .line_ready  (line_ready),
    .clear       (clear),
    .count       (count),
    .pixels      (pixels)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] str2line(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[(15-i)*8 +: 8] = s[i];
    return r;
  endfunction

  // Reference raster: headers at y 25..36, row r at y 25+(r+1)*50 .. +11,
  // column c at x 150+400c .. +127; glyph inked on rows 1..10 as
  // {1, code[6:0]} for codes 0x21..0x7E.
  function automatic logic [2:0] model_pix(input int h, input int v);
    logic [127:0] line;
    logic [7:0]   code;
    logic [7:0]   glyph;
    int           gr, ci, b, base, ys;
    logic         hity;
    model_pix = 3'b000;
    line = '0;
    gr   = 0;
    for (int c = 0; c < 2; c++) begin
      base = 150 + 400*c;
      if (h >= base && h < base + 128) begin
        ci   = (h - base) / 8;
        b    = (h - base) % 8;
        hity = 1'b0;
        if (v >= 25 && v < 37) begin
          line = hdr[c]; gr = v - 25; hity = 1'b1;
        end
        for (int r = 0; r < 5; r++) begin
          ys = 25 + (r+1)*50;
          if (v >= ys && v < ys + 12) begin
            line = exp_txt[c][r]; gr = v - ys; hity = 1'b1;
          end
        end
        if (hity) begin
          code  = line[(15-ci)*8 +: 8];
          glyph = (code > 8'h20 && code <= 8'h7E && gr >= 1 && gr <= 10) ? {1'b1, code[6:0]} : 8'h00;
          model_pix = {3{glyph[7-b]}};
        end
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sweep hcount across [h0,h1] on line v; each output is compared with the
  // pixel presented three clocks earlier.
  task automatic scan(input string tag, input int v, input int h0, input int h1);
    vcount = 10'(v);
    for (int i = 0; i <= h1 - h0 + 2; i++) begin
      hcount = 11'((h0 + i > h1) ? h1 : h0 + i);
      tick(1);
      if (i >= 2) check(tag, 32'(pixels), 32'(model_pix(h0 + i - 2, v)));
    end
  endtask

  task automatic push(input int ch, input string s);
    bit done;
    done       = 1'b0;
    line_valid = 1'b1;
    line_chan  = 1'(ch);
    line_data  = str2line(s);
    for (int i = 0; i < 16 && !done; i++) begin
      if (line_ready) done = 1'b1;
      tick(1);
    end
    line_valid = 1'b0;
    check("push_accept", 32'(done), 32'd1);
  endtask

  task automatic clear_expect();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 5; r++) exp_txt[c][r] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    hcount     = '0;
    vcount     = '0;
    line_valid = 1'b0;
    line_chan  = '0;
    line_data  = '0;
    clear      = '0;
    hdr[0]     = str2line("CHAN0");
    hdr[1]     = str2line("CHAN1");
    headers    = {hdr[1], hdr[0]};
    clear_expect();

    // ---- reset state and an empty frame
    tick(3);
    check("rst_count", 32'(count), 32'h00);
    check("rst_ready", 32'(line_ready), 32'd0);
    check("rst_pixels", 32'(pixels), 32'd0);
    reset_n = 1'b1;
    scan("hdr0", 26, 146, 195);
    scan("hdr1", 30, 546, 595);
    scan("empty_c0_r0", 76, 146, 195);
    scan("empty_c1_r4", 280, 546, 595);
    check("ready_active", 32'(line_ready), 32'd0);
    check("count_empty", 32'(count), 32'h00);

    // ---- ready opens only once vcount reaches 768
    vcount = 10'd767;
    tick(2);
    check("ready_767", 32'(line_ready), 32'd0);
    vcount = 10'd768;
    tick(1);
    check("ready_768", 32'(line_ready), 32'd1);

    // ---- first line
    push(0, "HELLO");
    exp_txt[0][0] = str2line("HELLO");
    check("count_hello", 32'(count), 32'h01);
    scan("hello_g1", 76, 146, 195);
    scan("hello_g10", 85, 146, 195);
    scan("hello_g11", 86, 146, 195);
    scan("hello_r1_blank", 126, 146, 195);

    // ---- wrap: seven lines into a five-deep history
    vcount = 10'd770;
    tick(2);
    for (int i = 1; i <= 7; i++) push(1, $sformatf("L%0d", i));
    for (int r = 0; r < 5; r++) exp_txt[1][r] = str2line($sformatf("L%0d", r + 3));
    check("count_wrap", 32'(count), 32'h51);
    for (int r = 0; r < 5; r++) scan($sformatf("wrap_r%0d", r), 76 + 50*r, 546, 575);

    // ---- push held off during active video
    vcount = 10'd100;
    tick(2);
    line_valid = 1'b1;
    line_chan  = 1'b0;
    line_data  = str2line("WAIT");
    tick(4);
    check("hold_ready", 32'(line_ready), 32'd0);
    check("hold_count", 32'(count), 32'h51);
    scan("hold_r1", 126, 146, 185);
    scan("hold_r0", 76, 146, 185);
    vcount = 10'd768;
    tick(1);
    check("hold_ready_open", 32'(line_ready), 32'd1);
    check("hold_not_yet", 32'(count), 32'h51);
    tick(1);
    line_valid = 1'b0;
    check("hold_accepted", 32'(count), 32'h52);
    exp_txt[0][1] = str2line("WAIT");
    scan("wait_r1", 126, 146, 185);

    // ---- clear beats a push to the same channel; other channel still pushes
    vcount = 10'd770;
    tick(2);
    check("clr_ready_pre", 32'(line_ready), 32'd1);
    clear      = 2'b01;
    line_valid = 1'b1;
    line_chan  = 1'b0;
    line_data  = str2line("X");
    tick(1);
    check("clr_ready", 32'(line_ready), 32'd0);
    check("clr_count", 32'(count), 32'h50);
    line_chan = 1'b1;
    line_data = str2line("L8");
    tick(1);
    check("clr_ready_ch1", 32'(line_ready), 32'd1);
    tick(1);
    line_valid = 1'b0;
    clear      = 2'b00;
    check("clr_count_after", 32'(count), 32'h50);
    clear_expect();
    for (int r = 0; r < 5; r++) exp_txt[1][r] = str2line($sformatf("L%0d", r + 4));
    scan("clr_c0_r0", 76, 146, 185);
    scan("clr_c0_r1", 126, 146, 185);
    scan("clr_c1_r0", 76, 546, 575);
    scan("clr_c1_r4", 276, 546, 575);

    // ---- asynchronous reset mid-frame
    vcount = 10'd770;
    tick(2);
    push(0, "A");
    push(0, "B");
    push(0, "C");
    check("count_abc", 32'(count), 32'h53);
    vcount = 10'd76;
    hcount = 11'd150;
    tick(4);
    check("pre_reset_pix", 32'(pixels), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pixels", 32'(pixels), 32'd0);
    check("async_rst_count", 32'(count), 32'h00);
    check("async_rst_ready", 32'(line_ready), 32'd0);
    tick(2);
    reset_n = 1'b1;
    clear_expect();
    check("post_rst_count", 32'(count), 32'h00);
    scan("post_hdr0", 30, 146, 195);
    scan("post_c0_r0", 76, 146, 185);
    scan("post_c0_r2", 176, 146, 185);
    scan("post_c1_r0", 80, 546, 575);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
